// File: rtl/idli_utx_ctl_m.sv
// UART TX controller: pairs EX nibbles into bytes, queues them in a byte FIFO and sends 8N1 frames.
// Define IDLI_UTX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module idli_utx_ctl_m #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 16
) (
    input  logic                   i_utx_gck,
    input  logic                   i_utx_rst_n,
    input  logic                   i_utx_vld,
    input  logic [3:0]             i_utx_data,
    output logic                   o_utx_acp,
    output logic [$clog2(DEPTH):0] o_utx_lvl,
    output logic                   o_utx_busy,
    output logic                   o_utx_tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef IDLI_UTX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          pend_r;
    logic [3:0]    low_r;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] baud_r;
    logic [CW-1:0] baud_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic          tx_r;
    logic          tx_s;
    logic          acp_s;
    logic          empty_s;
    logic          nib_s;
    logic          push_s;
    logic          pop_s;
    logic          baud_end_s;
`ifdef IDLI_UTX_PARITY_EN
    logic          par_r;
    logic          par_s;
`endif

    assign acp_s      = (count_r != LW'(DEPTH));
    assign empty_s    = (count_r == {LW{1'b0}});
    assign nib_s      = i_utx_vld & acp_s;
    assign push_s     = nib_s & pend_r;
    assign baud_end_s = (baud_r == CW'(BAUD_DIV - 1));

    // Serialiser next-state, next-bit and FIFO pop decision
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        pop_s   = 1'b0;
`ifdef IDLI_UTX_PARITY_EN
        par_s   = par_r;
`endif
        if (baud_end_s) begin
            baud_s = {CW{1'b0}};
        end else begin
            baud_s = baud_r + CW'(1);
        end
        case (state_r)
            ST_IDLE: begin
                baud_s = {CW{1'b0}};
                tx_s   = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
`ifdef IDLI_UTX_PARITY_EN
                    par_s   = ^mem_r[rd_ptr_r];
`endif
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s = ST_DATA;
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                end else begin
                    tx_s    = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
`ifdef IDLI_UTX_PARITY_EN
                        state_s = ST_PARITY;
                        tx_s    = par_r;
`else
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        tx_s    = shift_r[1];
                    end
                end else begin
                    tx_s = tx_r;
                end
            end
`ifdef IDLI_UTX_PARITY_EN
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_s = ST_STOP;
                    tx_s    = 1'b1;
                end else begin
                    tx_s    = tx_r;
                end
            end
`endif
            ST_STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit with no idle gap
                if (baud_end_s) begin
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
`ifdef IDLI_UTX_PARITY_EN
                        par_s   = ^mem_r[rd_ptr_r];
`endif
                        state_s = ST_START;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = {CW{1'b0}};
                tx_s    = 1'b1;
            end
        endcase
    end

    // State, pointer, occupancy and nibble-pending registers
    always_ff @(posedge i_utx_gck) begin
        if (!i_utx_rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {LW{1'b0}};
            pend_r   <= 1'b0;
            low_r    <= 4'h0;
            state_r  <= ST_IDLE;
            baud_r   <= {CW{1'b0}};
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            tx_r     <= 1'b1;
`ifdef IDLI_UTX_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            if (nib_s) begin
                pend_r <= ~pend_r;
                if (!pend_r) begin
                    low_r <= i_utx_data;
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r  <= count_r + LW'(push_s) - LW'(pop_s);
            state_r  <= state_s;
            baud_r   <= baud_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            tx_r     <= tx_s;
`ifdef IDLI_UTX_PARITY_EN
            par_r    <= par_s;
`endif
        end
    end

    // FIFO storage write
    always_ff @(posedge i_utx_gck) begin
        if (i_utx_rst_n && push_s) begin
            mem_r[wr_ptr_r] <= {i_utx_data, low_r};
        end
    end

    assign o_utx_acp  = acp_s;
    assign o_utx_lvl  = count_r;
    assign o_utx_busy = !empty_s || (state_r != ST_IDLE);
    assign o_utx_tx   = tx_r;
endmodule

// File: doc/idli_utx_ctl_m.md
Name: idli_utx_ctl_m

Overview:
- Owns the UART TX resource: collects nibble-serial bytes from EX into a byte FIFO, then serialises them onto the TX pin as 8N1 frames.
- Drives the TX accept signal that the clock-sync logic uses to stall on uart_tx_lo/uart_tx_hi.
- Sits between EX and the top-level TX pin; runs on the gated core clock.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, >= 2.
- BAUD_DIV, 16, clock cycles per UART bit; >= 2.

Ports:
- i_utx_gck  input  1  clock.
- i_utx_rst_n  input  1  synchronous active-low reset.
- i_utx_vld  input  1  nibble valid from EX.
- i_utx_data  input  4  nibble; low nibble of a byte first, then high nibble.
- o_utx_acp  output  1  FIFO can take a byte; combinational, equals count != DEPTH.
- o_utx_lvl  output  $clog2(DEPTH)+1  FIFO occupancy in bytes.
- o_utx_busy  output  1  FIFO non-empty or serialiser not IDLE.
- o_utx_tx  output  1  serial line, registered, idles high.

Behaviour:
- Reset: synchronous, active-low on i_utx_gck. Reset values: o_utx_tx=1, o_utx_lvl=0, o_utx_busy=0, o_utx_acp=1. FIFO pointers and nibble-pending flag cleared; serialiser enters IDLE. Reset mid-frame abandons the frame; tx is high from the first edge with rst_n low.
- Nibble assembly:
  - Nibble accepted when i_utx_vld && o_utx_acp.
  - pend=0: nibble stored as low half; pend<=1.
  - pend=1: byte {data, low} written to FIFO; pend<=0.
  - High nibble may arrive any later cycle. Space is guaranteed because only pops occur while pend=1.
  - i_utx_vld while o_utx_acp=0 is a protocol violation; the nibble is ignored and state is unchanged.
- FIFO:
  - Circular buffer with $clog2(DEPTH)-bit pointers that wrap DEPTH-1 -> 0.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full; no pop when empty.
- Serialiser FSM: IDLE, START, DATA, STOP; baud counter 0..BAUD_DIV-1; bit index 0..7.
  - IDLE: if FIFO non-empty, pop into shift register and go to START; tx<=0 at that edge.
  - START: hold 0 for BAUD_DIV cycles, then DATA with tx<=shift[0].
  - DATA: each bit held BAUD_DIV cycles, LSB first; after bit 7 go to STOP with tx<=1.
  - STOP: hold 1 for BAUD_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Latency: byte completed in cycle N -> FIFO non-empty in N+1 -> o_utx_tx low from N+2.
- Frame length: 10*BAUD_DIV cycles.
- o_utx_busy is computed from registered state only.

Optional Feature:
- Macro: IDLI_UTX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that transmits even parity (XOR of the 8 data bits) for BAUD_DIV cycles; frame becomes 11*BAUD_DIV cycles.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Test Plan:
- Reset, BAUD_DIV=4, DEPTH=4:
  - Stimulus: nibbles 0x5 then 0xA on consecutive cycles.
  - Expect o_utx_tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. Start bit begins 2 cycles after the 0xA nibble.
  - Expect o_utx_busy to fall after 40 cycles of frame.
- Fill FIFO without draining:
  - Stimulus: with serialiser IDLE, push 5 bytes (0x01..0x05) back-to-back.
  - Expect the first byte popped immediately and o_utx_lvl peaking at 4, with o_utx_acp=0 at lvl 4.
  - Expect an ignored extra nibble to leave lvl unchanged.
  - Expect bytes to appear in order with no idle cycles between stop and next start.
- Split byte:
  - Stimulus: low nibble 0x3, 7 idle cycles, high nibble 0xC.
  - Expect exactly one byte 0xC3 sent, and o_utx_lvl staying 0 until the high nibble.
- Simultaneous push/pop at full:
  - Stimulus: lvl=4 and STOP ends (pop) while EX completes a byte.
  - Expect lvl to go 4->3 on the pop, then 3->3 on a later same-cycle push+pop.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during DATA bit 3 of 0xFF with lvl=2 and pend=1.
  - Expect next edge tx=1, lvl=0, busy=0, acp=1.
  - Expect a subsequent 0x12 to transmit correctly, not a stale nibble.
- IDLI_UTX_PARITY_EN defined:
  - Byte 0x07 -> parity bit 1, frame 44 cycles at BAUD_DIV=4.
  - Byte 0xA5 -> parity bit 0.
